// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter sharing one up/down/load counter between two requesters.
// Latches the winner's command and paces counter steps with a programmable tick.
module counter_cmd_arbiter #(
    parameter int TICK_DIV = 100000000,
    parameter int TW       = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [2:0] cmd0,
    input  logic [3:0] data0,
    input  logic [3:0] len0,
    input  logic [2:0] cmd1,
    input  logic [3:0] data1,
    input  logic [3:0] len1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [2:0] ctrl_out,
    output logic [3:0] data_out,
    output logic       step,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [2:0]    CMD_LOAD  = 3'd3;
    localparam logic [2:0]    CMD_HOLD  = 3'd4;

    state_t        state;
    logic          ptr;        // requester favoured at the next arbitration
    logic          owner;
    logic [TW-1:0] tick;
    logic [3:0]    remaining;

    logic          win;
    logic [2:0]    win_cmd;
    logic [3:0]    win_data;
    logic [3:0]    win_len;
    logic [3:0]    win_steps;
    logic          tick_end;

    always_comb begin
        win      = req[ptr] ? ptr : ~ptr;
        win_cmd  = win ? cmd1  : cmd0;
        win_data = win ? data1 : data0;
        win_len  = win ? len1  : len0;
        if (win_cmd[2])
            win_steps = 4'd0;
        else if (win_cmd == CMD_LOAD || win_len == 4'd0)
            win_steps = 4'd1;
        else
            win_steps = win_len;
    end

    assign tick_end = (tick == TICK_LAST);
    assign busy     = (state != IDLE);

    // NOTE: step is decoded from registered state but gated by the live req so an
    // abort suppresses the step in the very cycle req drops, not one cycle later.
    assign step = (state == RUN) && req[owner] && (remaining != 4'd0) && tick_end;

    // NOTE: every register uses <= so all state advances together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            owner     <= 1'b0;
            tick      <= '0;
            remaining <= '0;
            gnt       <= '0;
            done      <= '0;
            ctrl_out  <= CMD_HOLD;
            data_out  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt       <= win ? 2'b10 : 2'b01;
                        owner     <= win;
                        ptr       <= ~win;
                        ctrl_out  <= win_cmd;
                        data_out  <= win_data;
                        remaining <= win_steps;
                        tick      <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        gnt      <= '0;
                        ctrl_out <= CMD_HOLD;
                        data_out <= '0;
                        tick     <= '0;
                        state    <= IDLE;
                    end else if (remaining == 4'd0 || (tick_end && remaining == 4'd1)) begin
                        gnt       <= '0;
                        done      <= owner ? 2'b10 : 2'b01;
                        ctrl_out  <= CMD_HOLD;
                        data_out  <= '0;
                        tick      <= '0;
                        remaining <= '0;
                        state     <= DONE;
                    end else if (tick_end) begin
                        tick      <= '0;
                        remaining <= remaining - 4'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
